// File: rtl/ibex_rf_write_sequencer.sv
// Write-port sequencer for the FPGA register file: clears x1..xN-1 after reset or on
// request, then arbitrates the single write port between writeback and a secondary requester.
module ibex_rf_write_sequencer #(
   parameter bit                   RV32E       = 1'b0,
   parameter int unsigned          DataWidth   = 32,
   parameter logic [DataWidth-1:0] WordZeroVal = '0,
   parameter int unsigned          StarveLimit = 4
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,

   input  logic                 clear_req_i,

   input  logic                 wb_we_i,
   input  logic [4:0]           wb_waddr_i,
   input  logic [DataWidth-1:0] wb_wdata_i,
   output logic                 stall_wb_o,
   output logic                 busy_o,

   input  logic                 dbg_req_i,
   input  logic [4:0]           dbg_waddr_i,
   input  logic [DataWidth-1:0] dbg_wdata_i,
   output logic                 dbg_gnt_o,

   output logic                 rf_we_o,
   output logic [4:0]           rf_waddr_o,
   output logic [DataWidth-1:0] rf_wdata_o,

   output logic                 done_o,
   output logic                 err_o
);

   localparam int unsigned        NumWords  = RV32E ? 16 : 32;
   localparam int unsigned        IdxW      = RV32E ? 4 : 5;
   localparam logic [IdxW-1:0]    FirstIdx  = IdxW'(1);
   localparam logic [IdxW-1:0]    LastIdx   = IdxW'(NumWords - 1);
   localparam logic [3:0]         StarveMax = 4'(StarveLimit);

   typedef enum logic [1:0] {
      StStart = 2'd0,
      StClear = 2'd1,
      StIdle  = 2'd2
   } state_e;

   state_e          state_q, state_d;
   logic [IdxW-1:0] idx_q, idx_d;
   logic [3:0]      starve_q, starve_d;
   logic            done_q, done_d;
   logic            err_q, err_d;

   logic            busy_s;
   logic            stall_s;
   logic            gnt_s;
   logic            we_s;
   logic [4:0]      waddr_s;
   logic [DataWidth-1:0] wdata_s;

   // Next-state logic and the combinational write-port mux.
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      starve_d = 4'd0;
      done_d   = 1'b0;
      busy_s   = 1'b1;
      stall_s  = 1'b0;
      gnt_s    = 1'b0;
      we_s     = 1'b0;
      waddr_s  = 5'd0;
      wdata_s  = '0;

      case (state_q)
         StStart: begin
            state_d = StClear;
         end

         StClear: begin
            we_s    = 1'b1;
            waddr_s = 5'(idx_q);
            wdata_s = WordZeroVal;
            if (idx_q == LastIdx) begin
               state_d = StIdle;
               idx_d   = FirstIdx;
               done_d  = 1'b1;
            end else begin
               idx_d   = idx_q + IdxW'(1);
            end
         end

         StIdle: begin
            busy_s = 1'b0;
            // A starved requester wins over writeback and forces the core to stall.
            if ((starve_q == StarveMax) && dbg_req_i) begin
               gnt_s   = 1'b1;
               stall_s = 1'b1;
            end else if (wb_we_i) begin
               we_s    = 1'b1;
               waddr_s = wb_waddr_i;
               wdata_s = wb_wdata_i;
            end else if (dbg_req_i) begin
               gnt_s   = 1'b1;
            end else begin
               we_s    = 1'b0;
            end

            if (gnt_s) begin
               we_s    = 1'b1;
               waddr_s = dbg_waddr_i;
               wdata_s = dbg_wdata_i;
            end else begin
               gnt_s   = 1'b0;
            end

            if (dbg_req_i && !gnt_s) begin
               starve_d = (starve_q == StarveMax) ? starve_q : (starve_q + 4'd1);
            end else begin
               starve_d = 4'd0;
            end

            if (clear_req_i) begin
               state_d = StStart;
            end else begin
               state_d = StIdle;
            end
         end

         default: begin
            state_d = StStart;
            idx_d   = FirstIdx;
         end
      endcase

      err_d = wb_we_i & (busy_s | stall_s);
   end

   // State, clear index, starvation counter and pulse flags.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= StStart;
         idx_q    <= FirstIdx;
         starve_q <= 4'd0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         starve_q <= starve_d;
         done_q   <= done_d;
         err_q    <= err_d;
      end
   end

   assign busy_o     = busy_s;
   assign stall_wb_o = stall_s;
   assign dbg_gnt_o  = gnt_s;
   assign rf_we_o    = we_s;
   assign rf_waddr_o = waddr_s;
   assign rf_wdata_o = wdata_s;
   assign done_o     = done_q;
   assign err_o      = err_q;

endmodule

// File: tb/tb_ibex_rf_write_sequencer.sv
// Self-checking bench: reset/clear timing, directed arbitration vectors, mid-clear reset,
// and randomized idle traffic against a request-level reference model.
module tb_ibex_rf_write_sequencer;

   localparam int          Limit = 4;
   localparam logic [31:0] Zval  = 32'hDEAD_BEEF;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        clear_req = 1'b0;
   logic        wb_we = 1'b0;
   logic [4:0]  wb_addr = 5'd0;
   logic [31:0] wb_data = 32'd0;
   logic        dbg_req = 1'b0;
   logic [4:0]  dbg_addr = 5'd0;
   logic [31:0] dbg_data = 32'd0;

   logic        stall, busy, gnt, rf_we, done, err;
   logic [4:0]  rf_addr;
   logic [31:0] rf_data;

   logic        e_stall, e_busy, e_gnt, e_we, e_done, e_err;
   logic [4:0]  e_addr;
   logic [31:0] e_data;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   ibex_rf_write_sequencer #(
      .RV32E(1'b0), .DataWidth(32), .WordZeroVal(Zval), .StarveLimit(Limit)
   ) dut (
      .clk_i(clk), .rst_ni(rst_n), .clear_req_i(clear_req),
      .wb_we_i(wb_we), .wb_waddr_i(wb_addr), .wb_wdata_i(wb_data),
      .stall_wb_o(stall), .busy_o(busy),
      .dbg_req_i(dbg_req), .dbg_waddr_i(dbg_addr), .dbg_wdata_i(dbg_data),
      .dbg_gnt_o(gnt),
      .rf_we_o(rf_we), .rf_waddr_o(rf_addr), .rf_wdata_o(rf_data),
      .done_o(done), .err_o(err)
   );

   ibex_rf_write_sequencer #(
      .RV32E(1'b1), .DataWidth(32), .WordZeroVal(32'h0000_0000), .StarveLimit(Limit)
   ) dut_e (
      .clk_i(clk), .rst_ni(rst_n), .clear_req_i(1'b0),
      .wb_we_i(1'b0), .wb_waddr_i(5'd0), .wb_wdata_i(32'd0),
      .stall_wb_o(e_stall), .busy_o(e_busy),
      .dbg_req_i(1'b0), .dbg_waddr_i(5'd0), .dbg_wdata_i(32'd0),
      .dbg_gnt_o(e_gnt),
      .rf_we_o(e_we), .rf_waddr_o(e_addr), .rf_wdata_o(e_data),
      .done_o(e_done), .err_o(e_err)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Expects reset to have been released just after a rising edge (that cycle is cycle 0).
   task automatic check_clear();
      int e_writes = 0;
      int m_writes = 0;
      for (int c = 0; c <= 32; c++) begin
         @(negedge clk);
         chk("clr_we", 32'(rf_we), 32'((c >= 1) && (c <= 31)));
         if ((c >= 1) && (c <= 31)) begin
            chk("clr_addr", 32'(rf_addr), c);
            chk("clr_data", rf_data, Zval);
            m_writes++;
         end
         chk("clr_done", 32'(done), 32'(c == 32));
         chk("clr_busy", 32'(busy), 32'(c < 32));
         chk("clr_gnt", 32'(gnt), 32'd0);
         chk("e_we", 32'(e_we), 32'((c >= 1) && (c <= 15)));
         if (e_we) begin
            chk("e_addr", 32'(e_addr), c);
            e_writes++;
         end
         chk("e_done", 32'(e_done), 32'(c == 16));
         chk("e_busy", 32'(e_busy), 32'(c < 16));
         next_cycle();
      end
      chk("clr_count", m_writes, 32'd31);
      chk("e_count", e_writes, 32'd15);
   endtask

   typedef struct {
      logic        wb_we;
      logic [4:0]  wb_addr;
      logic [31:0] wb_data;
      logic        dbg_req;
      logic [4:0]  dbg_addr;
      logic [31:0] dbg_data;
      logic        x_we;
      logic [4:0]  x_addr;
      logic [31:0] x_data;
      logic        x_gnt;
      logic        x_stall;
      logic        x_err;
   } vec_t;

   vec_t vecs[10];

   // random-phase model state
   typedef struct { logic [4:0] addr; logic [31:0] data; } req_t;
   req_t        pending[$];
   int          waited;
   logic        err_next;
   logic        m_we, m_gnt, m_stall, m_force;
   logic [4:0]  m_addr;
   logic [31:0] m_data;

   initial begin
      vecs[0] = '{1'b1, 5'd5,  32'h11, 1'b1, 5'd6, 32'h22, 1'b1, 5'd5,  32'h11, 1'b0, 1'b0, 1'b0};
      vecs[1] = '{1'b0, 5'd0,  32'h0,  1'b1, 5'd6, 32'h22, 1'b1, 5'd6,  32'h22, 1'b1, 1'b0, 1'b0};
      vecs[2] = '{1'b1, 5'd8,  32'h33, 1'b1, 5'd9, 32'h44, 1'b1, 5'd8,  32'h33, 1'b0, 1'b0, 1'b0};
      vecs[3] = '{1'b1, 5'd10, 32'h34, 1'b1, 5'd9, 32'h44, 1'b1, 5'd10, 32'h34, 1'b0, 1'b0, 1'b0};
      vecs[4] = '{1'b1, 5'd11, 32'h35, 1'b1, 5'd9, 32'h44, 1'b1, 5'd11, 32'h35, 1'b0, 1'b0, 1'b0};
      vecs[5] = '{1'b1, 5'd12, 32'h36, 1'b1, 5'd9, 32'h44, 1'b1, 5'd12, 32'h36, 1'b0, 1'b0, 1'b0};
      vecs[6] = '{1'b1, 5'd13, 32'h37, 1'b1, 5'd9, 32'h44, 1'b1, 5'd9,  32'h44, 1'b1, 1'b1, 1'b0};
      vecs[7] = '{1'b1, 5'd14, 32'h38, 1'b0, 5'd0, 32'h0,  1'b1, 5'd14, 32'h38, 1'b0, 1'b0, 1'b1};
      vecs[8] = '{1'b0, 5'd0,  32'h0,  1'b0, 5'd0, 32'h0,  1'b0, 5'd0,  32'h0,  1'b0, 1'b0, 1'b0};
      vecs[9] = '{1'b1, 5'd0,  32'h99, 1'b0, 5'd0, 32'h0,  1'b1, 5'd0,  32'h99, 1'b0, 1'b0, 1'b0};

      // Reset values while held in reset.
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd1);
      chk("rst_we", 32'(rf_we), 32'd0);
      chk("rst_gnt", 32'(gnt), 32'd0);
      chk("rst_stall", 32'(stall), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      next_cycle();
      rst_n = 1'b1;
      check_clear();

      // Directed arbitration vectors in IDLE.
      for (int i = 0; i < 10; i++) begin
         wb_we = vecs[i].wb_we;   wb_addr = vecs[i].wb_addr;   wb_data = vecs[i].wb_data;
         dbg_req = vecs[i].dbg_req; dbg_addr = vecs[i].dbg_addr; dbg_data = vecs[i].dbg_data;
         @(negedge clk);
         chk($sformatf("v%0d_we", i), 32'(rf_we), 32'(vecs[i].x_we));
         if (vecs[i].x_we) begin
            chk($sformatf("v%0d_addr", i), 32'(rf_addr), 32'(vecs[i].x_addr));
            chk($sformatf("v%0d_data", i), rf_data, vecs[i].x_data);
         end
         chk($sformatf("v%0d_gnt", i), 32'(gnt), 32'(vecs[i].x_gnt));
         chk($sformatf("v%0d_stall", i), 32'(stall), 32'(vecs[i].x_stall));
         chk($sformatf("v%0d_err", i), 32'(err), 32'(vecs[i].x_err));
         chk($sformatf("v%0d_busy", i), 32'(busy), 32'd0);
         next_cycle();
      end
      wb_we = 1'b0; dbg_req = 1'b0;

      // Clear request from IDLE, writeback during CLEAR, reset at idx 10.
      clear_req = 1'b1;
      @(negedge clk);
      chk("creq_we", 32'(rf_we), 32'd0);
      chk("creq_busy", 32'(busy), 32'd0);
      next_cycle();
      @(negedge clk);
      chk("start_busy", 32'(busy), 32'd1);
      chk("start_we", 32'(rf_we), 32'd0);
      next_cycle();
      for (int k = 1; k <= 10; k++) begin
         clear_req = (k == 6);
         wb_we = (k == 3); wb_addr = 5'd7; wb_data = 32'h55;
         dbg_req = (k == 5); dbg_addr = 5'd2; dbg_data = 32'h66;
         @(negedge clk);
         chk("rc_we", 32'(rf_we), 32'd1);
         chk("rc_addr", 32'(rf_addr), k);
         chk("rc_data", rf_data, Zval);
         chk("rc_gnt", 32'(gnt), 32'd0);
         chk("rc_err", 32'(err), 32'(k == 4));
         if (k < 10) next_cycle();
      end
      clear_req = 1'b0; wb_we = 1'b0; dbg_req = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      chk("mid_busy", 32'(busy), 32'd1);
      chk("mid_we", 32'(rf_we), 32'd0);
      chk("mid_gnt", 32'(gnt), 32'd0);
      chk("mid_stall", 32'(stall), 32'd0);
      chk("mid_done", 32'(done), 32'd0);
      chk("mid_err", 32'(err), 32'd0);
      next_cycle();
      rst_n = 1'b1;
      check_clear();

      // Randomized IDLE traffic against a request-level model.
      for (int r = 0; r < 40; r++) pending.push_back('{5'($urandom_range(0, 31)), $urandom});
      waited = 0;
      err_next = 1'b0;
      begin
         logic active = 1'b0;
         for (int n = 0; n < 600; n++) begin
            if (!active && (pending.size() > 0) && ($urandom_range(0, 2) == 0)) active = 1'b1;
            dbg_req = active;
            if (active) begin
               dbg_addr = pending[0].addr;
               dbg_data = pending[0].data;
            end
            wb_we = ($urandom_range(0, 99) < 75);
            wb_addr = 5'($urandom_range(0, 31));
            wb_data = $urandom;

            m_force = active && (waited >= Limit);
            m_gnt   = active && (m_force || !wb_we);
            m_stall = m_force;
            m_we    = wb_we || active;
            m_addr  = m_gnt ? pending[0].addr : wb_addr;
            m_data  = m_gnt ? pending[0].data : wb_data;

            @(negedge clk);
            chk("rnd_we", 32'(rf_we), 32'(m_we));
            if (m_we) begin
               chk("rnd_addr", 32'(rf_addr), 32'(m_addr));
               chk("rnd_data", rf_data, m_data);
            end
            chk("rnd_gnt", 32'(gnt), 32'(m_gnt));
            chk("rnd_stall", 32'(stall), 32'(m_stall));
            chk("rnd_err", 32'(err), 32'(err_next));

            err_next = wb_we && m_stall;
            if (m_gnt) begin
               void'(pending.pop_front());
               active = 1'b0;
               waited = 0;
            end else if (active) begin
               waited = waited + 1;
            end else begin
               waited = 0;
            end
            next_cycle();
         end
      end
      chk("rnd_drained_some", 32'(pending.size() < 40), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
